// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parametrised register file with one write port, RD_PORTS combinational read
// ports and a per-entry busy scoreboard.
//
// Uses:
//   - Integer register file: ZERO_REG=1. Entry 0 always reads zero, and writes
//     and issues to it are dropped.
//   - FP register file: ZERO_REG=0 and RD_PORTS=3, which gives the three
//     source operands of a fused multiply-add.
//
// Busy scoreboard:
//   - Issue sets an entry's busy bit. Writeback clears it.
//   - When an issue and a writeback hit the same address in the same cycle,
//     the issue wins. The data is still written.
//
// Compile-time option:
//   - REG_FILE_BYPASS_EN (macro). When defined, a write in progress is
//     forwarded to any read port addressing the same entry in the same cycle:
//     the port shows WD with busy 0.
//   - When undefined, reads show the pre-edge contents.
//
// Parameters:
//   DATA_W    entry width
//   ADDR_W    address width, depth = 2**ADDR_W
//   RD_PORTS  number of read ports (1..4)
//   ZERO_REG  1: entry 0 hardwired to zero, 0: entry 0 is ordinary
//
// Ports:
//   CLK             rising-edge clock
//   RST             asynchronous active-low reset
//   RA              packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RD              packed read data, port k at [k*DATA_W +: DATA_W]
//                   (combinational)
//   RD_BUSY         busy flag of the entry addressed by each port
//   WA/WD/WE        writeback address, data and enable
//   ISSUE_VALID     mark ISSUE_ADDR pending
//   ISSUE_ADDR      destination being issued
//   ISSUE_CONFLICT  issue targets an entry that is already busy and is not
//                   being written back this cycle (WAW), combinational
//   BUSY_ANY        OR of all stored busy bits
//
// Handshake:
//   - WE and ISSUE_VALID are single-cycle strobes with no ready.
//   - They are accepted unconditionally at the rising edge where they are
//     high.
//   - ISSUE_CONFLICT is informational. A conflicting issue still takes
//     effect.
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [RD_PORTS*ADDR_W-1:0]   RA,
  output logic [RD_PORTS*DATA_W-1:0]   RD,
  output logic [RD_PORTS-1:0]          RD_BUSY,
  input  logic [ADDR_W-1:0]            WA,
  input  logic [DATA_W-1:0]            WD,
  input  logic                         WE,
  input  logic                         ISSUE_VALID,
  input  logic [ADDR_W-1:0]            ISSUE_ADDR,
  output logic                         ISSUE_CONFLICT,
  output logic                         BUSY_ANY
);

  localparam int   DEPTH    = 1 << ADDR_W;
  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Accesses to entry 0 are dropped when it is the hardwired zero register.
  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = WE          & ~(HAS_ZERO & (WA == '0));
  assign iss_ok = ISSUE_VALID & ~(HAS_ZERO & (ISSUE_ADDR == '0));

  // -------------------------------------------------------------------------
  // Storage and scoreboard update.
  // The issue assignment comes after the writeback clear, so a same-address
  // collision leaves busy set: a newer producer is still outstanding.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[WA]  <= WD;
        busy[WA] <= 1'b0;
      end
      if (iss_ok) begin
        busy[ISSUE_ADDR] <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;
    logic              busy_k;

    assign ra_k = RA[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_k   = mem[ra_k];
      busy_k = busy[ra_k];
      if (HAS_ZERO && (ra_k == '0)) begin
        // Entry 0 is never written in this mode. The explicit mask keeps the
        // port at zero regardless of storage contents.
        rd_k   = '0;
        busy_k = 1'b0;
      end
`ifdef REG_FILE_BYPASS_EN
      else if (wr_ok && (WA == ra_k)) begin
        // Write-through: the consumer sees the value being written this
        // cycle, and the entry is no longer pending.
        rd_k   = WD;
        busy_k = 1'b0;
      end
`endif
    end

    assign RD[k*DATA_W +: DATA_W] = rd_k;
    assign RD_BUSY[k]             = busy_k;
  end

  // -------------------------------------------------------------------------
  // Scoreboard status
  // -------------------------------------------------------------------------
  // A writeback to the same entry in the same cycle retires the old
  // producer, so the new issue is not a WAW hazard.
  assign ISSUE_CONFLICT = iss_ok & busy[ISSUE_ADDR] & ~(WE & (WA == ISSUE_ADDR));

  assign BUSY_ANY = |busy;

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the core's single-write, dual-read register file. It serves as either the integer register file (x0 hardwired to zero) or the F-extension register file (three read ports for fused multiply-add, no zero register). It adds a per-entry busy scoreboard so multi-cycle FP operations can mark their destination pending at issue and clear it at writeback. An optional write-through bypass is selected at compile time.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- RD_PORTS, 3, number of read ports (1..4); port k uses bits [k*ADDR_W +: ADDR_W] of RA and [k*DATA_W +: DATA_W] of RD
- ZERO_REG, 1, 1: entry 0 reads 0, ignores writes and issues; 0: entry 0 is ordinary

- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous active-low reset
- RA  in  RD_PORTS*ADDR_W  read addresses, packed
- RD  out  RD_PORTS*DATA_W  read data, packed, combinational
- RD_BUSY  out  RD_PORTS  busy flag of the addressed entry, per port
- WA  in  ADDR_W  write address
- WD  in  DATA_W  write data
- WE  in  1  write enable (writeback)
- ISSUE_VALID  in  1  mark ISSUE_ADDR pending
- ISSUE_ADDR  in  ADDR_W  destination being issued
- ISSUE_CONFLICT  out  1  ISSUE_VALID to an entry already busy (WAW), combinational
- BUSY_ANY  out  1  OR of all busy bits, registered view

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits.
- Write: on rising CLK with WE=1, mem[WA] <= WD and busy[WA] <= 0.
- Issue: on rising CLK with ISSUE_VALID=1, busy[ISSUE_ADDR] <= 1.
- Simultaneous issue and writeback to the same address: the issue wins. Data is written and busy ends at 1, because a new producer is pending.
- Writeback to a non-busy entry is legal: data is written and busy stays 0.
- ZERO_REG=1: writes and issues to address 0 are dropped. RD for address 0 is 0. RD_BUSY for address 0 is 0. ISSUE_CONFLICT is never raised for address 0.
- Read: RD port k = mem[RA_k]. Every port is independent, and duplicate addresses across ports are allowed.
- ISSUE_CONFLICT = ISSUE_VALID & busy[ISSUE_ADDR] & ~(WE & WA==ISSUE_ADDR). It is informational only; the issue still takes effect.
- BUSY_ANY = |busy, computed from the current register state.

## Timing
- Reads have zero latency (combinational from RA and stored state).
- Writes and busy updates take effect at the rising edge and are visible on RD and RD_BUSY in the following cycle. Bypass mode changes this; see Configuration.
- Reset (RST=0, asynchronous) clears all entries and all busy bits. After reset, RD=0, RD_BUSY=0, BUSY_ANY=0, and ISSUE_CONFLICT=0 unless driven by the inputs.
- Reset asserted mid-operation discards all pending state. A writeback in the same cycle as reset release is not captured.

## Configuration
- REG_FILE_BYPASS_EN defined: write-through forwarding. On port k, if WE=1 and WA==RA_k (and the address is not 0 when ZERO_REG=1), then RD_k = WD and RD_BUSY_k = 0 in the same cycle.
- REG_FILE_BYPASS_EN not defined: RD and RD_BUSY show pre-edge state; the new value appears one cycle after the write.

## Test plan
- Reset then read all addresses: RD=0, RD_BUSY=0, BUSY_ANY=0. Then write 0xDEADBEEF to 5 and read it back on all 3 ports the next cycle: 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to 0 and issue to 0, then read 0. RD=0, RD_BUSY=0, BUSY_ANY=0. Repeat with ZERO_REG=0: reads 0x12345678 and busy=1.
- Issue to 7, then set RA_0=7: RD_BUSY[0]=1 and BUSY_ANY=1. Issue 7 again: ISSUE_CONFLICT=1. Write 0xA5A5A5A5 to 7: busy clears the next cycle.
- Same cycle ISSUE_ADDR=9 and WA=9 with WE=1, WD=0x1: next cycle RD=0x1, RD_BUSY=1, and ISSUE_CONFLICT was 0 during the collision.
- With REG_FILE_BYPASS_EN defined: write 0xCAFEF00D to 3 while RA_2=3. RD_2 is 0xCAFEF00D in the same cycle. Without the macro, RD_2 shows the old value and updates the following cycle.
- Pull RST low asynchronously mid-cycle with entries 1..31 written and busy: all outputs go to 0 immediately, before the next clock edge.
